// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  localparam int unsigned MEM_WIDTH_DEF = 8;

  // Command word is two opcode bits on top of the RAM data width.
  function automatic int unsigned frame_bits(input int unsigned mem_width);
    return mem_width + 2;
  endfunction

  localparam int unsigned FRAME_BITS = frame_bits(MEM_WIDTH_DEF);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData,
    StWaitTx,
    StShiftOut,
    StDone
  } state_e;

endpackage

// File: rtl/spi_miso_serializer.sv
// Parallel-load, MSB-first shift register that feeds MISO.
module spi_miso_serializer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             clr,
  input  logic [Width-1:0] data,
  output logic             miso,
  output logic             done
);

  localparam int unsigned CntW = $clog2(Width);

  logic [Width-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Last bit is on the line while the counter sits at Width-1.
  assign done = en && (cnt_q == CntW'(Width - 1));
  assign miso = sreg_q[Width-1];

  // Next-state for shift register and bit counter; clear beats load beats shift.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (clr) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (load) begin
      sreg_d = data;
      cnt_d  = '0;
    end else if (en) begin
      sreg_d = {sreg_q[Width-2:0], 1'b0};
      cnt_d  = done ? '0 : cnt_q + 1'b1;
    end
  end

  // Shift register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit command frames for the RAM and
// serialises read data back out on MISO.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = 8,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [MEM_WIDTH+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [MEM_WIDTH-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int unsigned FrameW = frame_bits(MEM_WIDTH);
  localparam int unsigned CntW   = $clog2(FrameW);

  if (ADDR_SIZE > MEM_WIDTH) begin : gen_cfg_err
    $error("ADDR_SIZE must not exceed MEM_WIDTH");
  end

  state_e              state_q, state_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  // Holds frame bits 9..1; bit 0 is taken straight from MOSI on completion.
  logic [FrameW-2:0]   shift_q, shift_d;
  logic [FrameW-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rd_addr_flag_q, rd_addr_flag_d;

  logic abort;
  logic frame_last;
  logic ser_load, ser_en, ser_clr, ser_miso, ser_done;

  assign abort      = (state_q != StIdle) && SS_n;
  assign frame_last = (bit_cnt_q == CntW'(FrameW - 1));

  spi_miso_serializer #(
    .Width (MEM_WIDTH)
  ) u_miso_ser (
    .clk  (clk),
    .rst  (rst),
    .load (ser_load),
    .en   (ser_en),
    .clr  (ser_clr),
    .data (tx_data),
    .miso (ser_miso),
    .done (ser_done)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_flag_q <= rd_addr_flag_d;
    end
  end

  // Next-state logic; deselect wins over everything, including a completing bit.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:     if (!SS_n) state_d = StChkCmd;
        StChkCmd:   state_d = !MOSI ? StWrite : (rd_addr_flag_q ? StReadData : StReadAdd);
        StWrite:    if (frame_last) state_d = StDone;
        StReadAdd:  if (frame_last) state_d = StDone;
        StReadData: if (frame_last) state_d = StWaitTx;
        StWaitTx:   if (tx_valid) state_d = StShiftOut;
        StShiftOut: if (ser_done) state_d = StDone;
        StDone:     state_d = StDone;
        default:    state_d = StIdle;
      endcase
    end
  end

  // Datapath and serializer control for the current state.
  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_flag_d = rd_addr_flag_q;
    ser_load       = 1'b0;
    ser_en         = 1'b0;
    ser_clr        = 1'b0;
    if (abort) begin
      bit_cnt_d = '0;
      ser_clr   = 1'b1;
      // A read that was cut off mid shift-out still consumes the address.
      if (state_q == StShiftOut) rd_addr_flag_d = 1'b0;
    end else begin
      case (state_q)
        StChkCmd: begin
          shift_d   = {shift_q[FrameW-3:0], MOSI};
          bit_cnt_d = CntW'(1);
        end
        StWrite, StReadAdd, StReadData: begin
          if (frame_last) begin
            rx_data_d  = {shift_q, MOSI};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            if (state_q == StReadAdd) rd_addr_flag_d = 1'b1;
          end else begin
            shift_d   = {shift_q[FrameW-3:0], MOSI};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StWaitTx:   ser_load = tx_valid;
        StShiftOut: begin
          ser_en = 1'b1;
          if (ser_done) rd_addr_flag_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs; MISO is only live while shifting out.
  always_comb begin
    MISO     = (state_q == StShiftOut) ? ser_miso : 1'b0;
    rx_data  = rx_data_q;
    rx_valid = rx_valid_q;
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed and randomized bench for spi_slave_if with a frame-level model.
module tb_spi_slave_if;
  import spi_pkg::*;

  logic       clk;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks = 0;
  int errors = 0;

  // Frame-level model state.
  bit         exp_flag = 1'b0;
  logic [9:0] exp_rx   = '0;

  spi_slave_if #(
    .MEM_WIDTH (8),
    .ADDR_SIZE (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Shift the first n bits of f (MSB first); rx_valid may only rise after bit 0.
  task automatic send_bits(input logic [9:0] f, input int n, input bit spur);
    for (int i = 0; i < n; i++) begin
      MOSI = f[9-i];
      if (spur) begin
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
      end
      tick();
      check("rx_valid_bit", rx_valid, (i == 9));
      check("miso_quiet_rx", MISO, 1'b0);
    end
    tx_valid = 1'b0;
  endtask

  // Expected MISO stream is just the byte, MSB first, over 8 cycles.
  task automatic serve_read(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("miso_bit", MISO, b[7]);
    for (int k = 6; k >= 0; k--) begin
      tick();
      check("miso_bit", MISO, b[k]);
    end
    tick();
    check("miso_after", MISO, 1'b0);
    exp_flag = 1'b0;
  endtask

  // One complete select/frame/deselect transaction against the model.
  task automatic run_frame(input logic [9:0] f, input logic [7:0] b, input bit spur);
    bit rd_data;
    rd_data = f[9] && exp_flag;
    SS_n = 1'b0;
    tick();
    send_bits(f, 10, spur);
    check("rx_data", rx_data, f);
    exp_rx = f;
    if (f[9] && !exp_flag) exp_flag = 1'b1;
    if (rd_data) serve_read(b);
    check("rd_flag", dut.rd_addr_flag_q, exp_flag);
    SS_n = 1'b1;
    tick();
    check("idle_after", dut.state_q, StIdle);
    check("rx_hold", rx_data, exp_rx);
  endtask

  initial begin
    logic [9:0] f;
    logic [7:0] b;
    rst      = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 10'h000);
    check("rst_miso", MISO, 1'b0);
    check("rst_flag", dut.rd_addr_flag_q, 1'b0);
    check("rst_state", dut.state_q, StIdle);

    // Spurious tx_valid while idle.
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      tick();
      check("idle_spur_miso", MISO, 1'b0);
    end
    tx_valid = 1'b0;

    // Write pair, then random writes with spurious tx_valid.
    run_frame(10'h005, 8'h00, 1'b0);
    run_frame(10'h1AA, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      f = {1'b0, 9'($urandom)};
      run_frame(f, 8'h00, 1'b1);
    end

    // Read pair with the documented byte, then random read pairs.
    run_frame(10'h205, 8'h00, 1'b0);
    check("flag_set", dut.rd_addr_flag_q, 1'b1);
    f = {CMD_RD_DATA, 8'($urandom)};
    run_frame(f, 8'hC3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      f = {CMD_RD_ADDR, 8'($urandom)};
      run_frame(f, 8'h00, 1'b0);
      f = {CMD_RD_DATA, 8'($urandom)};
      b = 8'($urandom);
      run_frame(f, b, 1'b0);
    end

    // Abort a write after 5 bits.
    f = {CMD_WR_DATA, 8'($urandom)};
    SS_n = 1'b0;
    tick();
    send_bits(f, 5, 1'b0);
    SS_n = 1'b1;
    tick();
    check("abort_wr_valid", rx_valid, 1'b0);
    check("abort_wr_state", dut.state_q, StIdle);
    check("abort_wr_hold", rx_data, exp_rx);
    run_frame({CMD_WR_ADDR, 8'($urandom)}, 8'h00, 1'b0);

    // Abort during READ_ADD keeps the flag clear.
    SS_n = 1'b0;
    tick();
    send_bits({CMD_RD_ADDR, 8'hA5}, 3, 1'b0);
    SS_n = 1'b1;
    tick();
    check("abort_ra_flag", dut.rd_addr_flag_q, 1'b0);
    check("abort_ra_state", dut.state_q, StIdle);

    // Abort during SHIFT_OUT after 3 bits.
    run_frame({CMD_RD_ADDR, 8'($urandom)}, 8'h00, 1'b0);
    b = 8'($urandom);
    SS_n = 1'b0;
    tick();
    send_bits({CMD_RD_DATA, 8'($urandom)}, 10, 1'b0);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
    check("so_abort_b7", MISO, b[7]);
    tick();
    check("so_abort_b6", MISO, b[6]);
    tick();
    check("so_abort_b5", MISO, b[5]);
    SS_n = 1'b1;
    tick();
    exp_flag = 1'b0;
    exp_rx   = rx_data;
    check("so_abort_miso", MISO, 1'b0);
    check("so_abort_flag", dut.rd_addr_flag_q, 1'b0);
    check("so_abort_state", dut.state_q, StIdle);

    // Reset during READ_DATA bit 6.
    run_frame({CMD_RD_ADDR, 8'($urandom)}, 8'h00, 1'b0);
    f = {CMD_RD_DATA, 8'hFF};
    SS_n = 1'b0;
    tick();
    send_bits(f, 3, 1'b0);
    MOSI = f[6];
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
    SS_n = 1'b1;
    exp_flag = 1'b0;
    exp_rx   = '0;
    check("rst_mid_valid", rx_valid, 1'b0);
    check("rst_mid_miso", MISO, 1'b0);
    check("rst_mid_flag", dut.rd_addr_flag_q, 1'b0);
    check("rst_mid_state", dut.state_q, StIdle);
    check("rst_mid_rx", rx_data, 10'h000);
    tick();

    // Deselect on the completing bit drops the frame.
    f = {CMD_WR_DATA, 8'($urandom)};
    SS_n = 1'b0;
    tick();
    send_bits(f, 9, 1'b0);
    MOSI = f[0];
    SS_n = 1'b1;
    tick();
    check("late_abort_valid", rx_valid, 1'b0);
    check("late_abort_state", dut.state_q, StIdle);
    check("late_abort_hold", rx_data, exp_rx);

    // Read-data frame whose second bit is 0 is forwarded as received.
    run_frame({CMD_RD_ADDR, 8'($urandom)}, 8'h00, 1'b0);
    f = {CMD_RD_ADDR, 8'($urandom)};
    b = 8'($urandom);
    run_frame(f, b, 1'b0);
    check("rd10_flag", dut.rd_addr_flag_q, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
